abc_window_avg: RTL and testbench
=================================

Name: abc_window_avg

Overview:
- Streaming stage directly downstream of the addABC fixed-point adder; consumes its signed Q5.2 result (format [4:-2]).
- Accumulates a power-of-two window of samples, then presents the exact window sum and the rounded, saturated window mean through a valid/ready output handshake.
- Applies back-pressure upstream through in_ready while a result is pending.

Parameters:
- LOG2W, 3, log2 of window length; window W = 2**LOG2W samples; legal range 1..6.
- IW, 7, input/mean width in bits (Q5.2, bit range [4:-2]).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- clr  in  1  synchronous clear: discards the partial window.
- abc_in  in  IW  signed sample, format [4:-2] (raw -64..63 = -16.0..15.75).
- in_valid  in  1  abc_in is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- sum_out  out  IW+LOG2W  signed exact window sum, format [4+LOG2W:-2].
- mean_out  out  IW  signed rounded mean, format [4:-2].
- out_valid  out  1  sum_out and mean_out are valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (async, rst=1):
  - state=ACC, cnt=0, acc=0.
  - sum_out=0, mean_out=0, out_valid=0.
  - in_ready=0 while rst is high; in_ready=1 from the first clock edge after rst deasserts.
- FSM states: ACC, HOLD.
- ACC state:
  - in_ready=1.
  - An accept happens when in_valid=1 and in_ready=1; it sets acc += sign-extended abc_in and cnt += 1.
  - On the accept where cnt==W-1:
    - Compute final = acc + abc_in.
    - Register sum_out=final and mean_out=round_sat(final).
    - Set acc=0, cnt=0, out_valid=1, and go to HOLD.
  - Latency: out_valid rises on the clock edge that accepts the W-th sample.
- HOLD state:
  - in_ready=0, out_valid=1; sum_out and mean_out are held stable.
  - When out_ready=1: out_valid=0 at the next edge and the FSM returns to ACC.
  - No sample is accepted in the same cycle as the output handshake.
- round_sat(s):
  - Compute r = (s + 2**(LOG2W-1)) >>> LOG2W as an arithmetic shift, i.e. round half toward +inf.
  - Clamp r to [-64, 63] raw. The clamp cannot trigger for legal inputs but is mandatory.
- Accumulator width: IW+LOG2W bits, which is overflow-free by construction.
- clr:
  - In ACC: acc=0 and cnt=0 at the next edge. Any sample presented in that same cycle is dropped, but in_ready stays 1.
  - In HOLD: clr is ignored and the pending result is preserved.
- Priority: rst > clr > accept.
- out_ready while out_valid=0 has no effect.
- A reset mid-window or mid-HOLD discards everything. The next result requires W fresh accepts.

Decomposition:
- Shared package fxp_pkg holds:
  - Format constants ABC_INT=5, ABC_FRAC=2, ABC_W=7.
  - Raw saturation bounds ABC_MAX=63, ABC_MIN=-64.
  - The state enum {ACC, HOLD}.
- One combinational sub-module, fxp_round_sat: parameterised shift and output width; implements round-half-up plus clamp. It is reusable by other requantising stages.

Test Plan (W=8):
- Constant input: 8 accepts of 7'b0110100 (raw 52, 13.0) with out_ready=1 → out_valid on the 8th-accept edge; sum_out=raw 416 (104.0); mean_out=raw 52.
- Rounding at +half: seven raw 0 plus one raw 4 → sum 4, mean 1. Seven raw 0 plus one raw 3 → sum 3, mean 0.
- Rounding at -half: seven raw 0 plus one raw -4 → sum -4, mean 0. Eight raw -1 → sum -8, mean -1.
- Extremes: eight raw 63 → sum 504, mean 63. Eight raw -64 → sum -512, mean -64.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 → in_ready=0 and outputs stable throughout. Raise out_ready → out_valid=0 next edge, in_ready=1. The following window sums only new samples.
- Reset and clear:
  - Assert rst asynchronously after 3 accepts → all outputs 0 immediately.
  - After release, 8 new samples of raw 8 → sum 64, mean 8.
  - clr after 5 accepts → the next out_valid requires 8 further accepts.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the addABC result format (Q5.2, bits [4:-2])
// and the control state type used by the stages that consume it.
package fxp_pkg;

  localparam int ABC_INT  = 5;
  localparam int ABC_FRAC = 2;
  localparam int ABC_W    = ABC_INT + ABC_FRAC;

  localparam int ABC_MAX = 63;
  localparam int ABC_MIN = -64;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/abc_window_avg_if.sv
// Stream bundle for the window averager: sample input side and result output side.
interface abc_window_avg_if #(
  parameter int IW    = 7,
  parameter int LOG2W = 3
);

  logic signed [IW-1:0]       abc_in;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [IW+LOG2W-1:0] sum_out;
  logic signed [IW-1:0]       mean_out;
  logic                       out_valid;
  logic                       out_ready;

  modport slave (
    input  abc_in, in_valid, out_ready,
    output in_ready, sum_out, mean_out, out_valid
  );

  modport master (
    output abc_in, in_valid, out_ready,
    input  in_ready, sum_out, mean_out, out_valid
  );

endinterface

// File: rtl/fxp_round_sat.sv
// Combinational requantiser: divides by 2**SHIFT with round-half-up (toward +inf)
// and clamps the result into a signed OW-bit range.
module fxp_round_sat #(
  parameter int SW    = 10,
  parameter int SHIFT = 3,
  parameter int OW    = 7
) (
  input  logic signed [SW-1:0] s,
  output logic signed [OW-1:0] r
);

  // One extra bit keeps the rounding bias from overflowing the input range.
  localparam int EW = SW + 1;

  localparam logic signed [EW-1:0] HALF = EW'(1 << (SHIFT - 1));
  localparam logic signed [EW-1:0] RMAX = EW'((1 << (OW - 1)) - 1);
  localparam logic signed [EW-1:0] RMIN = EW'(-(1 << (OW - 1)));

  function automatic logic signed [EW-1:0] round_half_up(input logic signed [SW-1:0] v);
    logic signed [EW-1:0] biased;
    biased = EW'(v) + HALF;
    return biased >>> SHIFT;
  endfunction

  function automatic logic signed [OW-1:0] sat(input logic signed [EW-1:0] v);
    logic signed [EW-1:0] c;
    if (v > RMAX) begin
      c = RMAX;
    end else if (v < RMIN) begin
      c = RMIN;
    end else begin
      c = v;
    end
    return c[OW-1:0];
  endfunction

  always_comb begin
    r = sat(round_half_up(s));
  end

endmodule

// File: rtl/abc_window_avg.sv
// Window accumulator behind the addABC adder: sums 2**LOG2W samples, then holds
// the exact sum and rounded mean until downstream takes them.
module abc_window_avg
  import fxp_pkg::*;
#(
  parameter int LOG2W = 3,
  parameter int IW    = ABC_W
) (
  input logic             clk,
  input logic             rst,
  input logic             clr,
  abc_window_avg_if.slave bus
);

  localparam int SW = IW + LOG2W;

  state_t               state_q, state_d;
  logic [LOG2W-1:0]     cnt_q, cnt_d;
  logic signed [SW-1:0] acc_q, acc_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic signed [IW-1:0] mean_q, mean_d;
  logic                 vld_q, vld_d;
  logic                 rdy_q, rdy_d;

  logic signed [SW-1:0] final_sum;
  logic signed [IW-1:0] mean_rs;
  logic                 accept;
  logic                 last;

  // Accumulator is wide enough for W full-scale samples, so no wrap is possible.
  assign final_sum = acc_q + SW'(bus.abc_in);
  assign accept    = bus.in_valid && rdy_q;
  assign last      = (cnt_q == {LOG2W{1'b1}});

  fxp_round_sat #(
    .SW    (SW),
    .SHIFT (LOG2W),
    .OW    (IW)
  ) u_round_sat (
    .s (final_sum),
    .r (mean_rs)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    mean_d  = mean_q;
    vld_d   = vld_q;
    case (state_q)
      ACC: begin
        if (clr) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (last) begin
            sum_d   = final_sum;
            mean_d  = mean_rs;
            acc_d   = '0;
            cnt_d   = '0;
            vld_d   = 1'b1;
            state_d = HOLD;
          end else begin
            acc_d = final_sum;
            cnt_d = cnt_q + LOG2W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          vld_d   = 1'b0;
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
    // Ready is registered so it stays low until the first edge out of reset.
    rdy_d = (state_d == ACC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      mean_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      mean_q  <= mean_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.sum_out   = sum_q;
  assign bus.mean_out  = mean_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_abc_window_avg.sv
// Directed bench for abc_window_avg with W=8: table of full windows plus
// hand-written back-pressure, reset and clear sequences.
module tb_abc_window_avg;

  localparam int LOG2W = 3;
  localparam int IW    = 7;
  localparam int W     = 1 << LOG2W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;

  int checks = 0;
  int errors = 0;

  abc_window_avg_if #(.IW(IW), .LOG2W(LOG2W)) bus ();

  abc_window_avg #(.LOG2W(LOG2W), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    s [8];
    int    exp_sum;
    int    exp_mean;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    int t;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 1);
    bus.abc_in   = 7'(v);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_window(input string nm, input int s [8], input int es, input int em,
                            input bit handshake);
    bus.out_ready = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) chk({nm, "_early_valid"}, 32'(bus.out_valid), 0);
      send(s[i]);
    end
    chk({nm, "_valid"}, 32'(bus.out_valid), 1);
    chk({nm, "_in_ready_hold"}, 32'(bus.in_ready), 0);
    chk({nm, "_sum"}, 32'(bus.sum_out), es);
    chk({nm, "_mean"}, 32'(bus.mean_out), em);
    if (handshake) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({nm, "_valid_drop"}, 32'(bus.out_valid), 0);
      chk({nm, "_in_ready_back"}, 32'(bus.in_ready), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones [8];
    int twos [8];
    int eights [8];
    int tens [8];
    int s_hold;
    int m_hold;

    vecs[0] = '{"const52",  '{52, 52, 52, 52, 52, 52, 52, 52}, 416, 52};
    vecs[1] = '{"half_pos", '{0, 0, 0, 0, 0, 0, 0, 4}, 4, 1};
    vecs[2] = '{"below_half", '{0, 0, 0, 0, 0, 0, 0, 3}, 3, 0};
    vecs[3] = '{"half_neg", '{0, 0, 0, 0, 0, 0, 0, -4}, -4, 0};
    vecs[4] = '{"neg_one",  '{-1, -1, -1, -1, -1, -1, -1, -1}, -8, -1};
    vecs[5] = '{"max63",    '{63, 63, 63, 63, 63, 63, 63, 63}, 504, 63};
    vecs[6] = '{"min64",    '{-64, -64, -64, -64, -64, -64, -64, -64}, -512, -64};
    vecs[7] = '{"ramp",     '{1, 2, 3, 4, 5, 6, 7, 8}, 36, 5};
    vecs[8] = '{"neg_1p5",  '{-12, 0, 0, 0, 0, 0, 0, 0}, -12, -1};
    ones   = '{1, 1, 1, 1, 1, 1, 1, 1};
    twos   = '{2, 2, 2, 2, 2, 2, 2, 2};
    eights = '{8, 8, 8, 8, 8, 8, 8, 8};
    tens   = '{10, 10, 10, 10, 10, 10, 10, 10};

    bus.abc_in    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state and ready release
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_sum", 32'(bus.sum_out), 0);
    chk("rst_mean", 32'(bus.mean_out), 0);
    tick();
    tick();
    chk("rst_in_ready_held", 32'(bus.in_ready), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    foreach (vecs[i]) begin
      run_window(vecs[i].name, vecs[i].s, vecs[i].exp_sum, vecs[i].exp_mean, 1'b1);
    end

    // Back-pressure: result held, samples refused
    run_window("bp", tens, 80, 10, 1'b0);
    bus.abc_in   = 7'(50);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_sum_stable", 32'(bus.sum_out), 80);
      chk("bp_mean_stable", 32'(bus.mean_out), 10);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("bp_valid_drop", 32'(bus.out_valid), 0);
    chk("bp_in_ready_back", 32'(bus.in_ready), 1);
    run_window("bp_next", twos, 16, 2, 1'b1);

    // Async reset mid-window clears stale outputs immediately
    send(20);
    send(20);
    send(20);
    #2 rst = 1'b1;
    #1;
    chk("arst_sum", 32'(bus.sum_out), 0);
    chk("arst_mean", 32'(bus.mean_out), 0);
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_in_ready_back", 32'(bus.in_ready), 1);
    run_window("after_rst", eights, 64, 8, 1'b1);

    // Clear after 5 accepts drops the partial window and the sample presented with it
    for (int i = 0; i < 5; i++) send(10);
    clr          = 1'b1;
    bus.abc_in   = 7'(30);
    bus.in_valid = 1'b1;
    tick();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_in_ready", 32'(bus.in_ready), 1);
    chk("clr_valid", 32'(bus.out_valid), 0);
    run_window("after_clr", ones, 8, 1, 1'b0);

    // Clear while holding leaves the result intact
    s_hold = 8;
    m_hold = 1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_hold_valid", 32'(bus.out_valid), 1);
    chk("clr_hold_sum", 32'(bus.sum_out), s_hold);
    chk("clr_hold_mean", 32'(bus.mean_out), m_hold);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("clr_hold_drop", 32'(bus.out_valid), 0);
    run_window("final", twos, 16, 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
